// File: rtl/shape_dump_pkg.sv
// Shared constants and helpers for the shape-table UART dump.
// Frame layout: header, count, 11 bytes per shape, XOR checksum.
package shape_dump_pkg;

  localparam int INT_BITS = 12;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         SHAPE_BYTES = 11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    LOAD,
    FIELD,
    CSUM,
    FIN
  } state_e;

  // One shape, already widened to its on-wire 16-bit representation.
  typedef struct packed {
    logic [7:0]  ty;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] size;
    logic [15:0] angle;
    logic [11:0] color;
  } shape_t;

  function automatic logic [7:0] shape_byte(input shape_t s, input logic [3:0] k);
    logic [7:0] b;
    case (k)
      4'd0:    b = s.ty;
      4'd1:    b = s.x[15:8];
      4'd2:    b = s.x[7:0];
      4'd3:    b = s.y[15:8];
      4'd4:    b = s.y[7:0];
      4'd5:    b = s.size[15:8];
      4'd6:    b = s.size[7:0];
      4'd7:    b = s.angle[15:8];
      4'd8:    b = s.angle[7:0];
      4'd9:    b = {4'h0, s.color[11:8]};
      default: b = s.color[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shape_dump_uart.sv
// 8N1 byte serialiser. ready looks ahead to the last stop-bit cycle so the
// next byte is accepted on the same edge the current one ends (no idle gap).
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sh_q, sh_d;
  logic          tx_q;
  logic          bit_end, last_bit;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign last_bit = bit_end && (bit_q == 4'd9);
  assign ready_o  = !active_q || last_bit;
  assign busy_o   = active_q;
  assign tx_o     = tx_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    if (valid_i && ready_o) begin
      sh_d     = {1'b1, data_i, 1'b0};
      cnt_d    = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
        sh_d  = {1'b1, sh_q[9:1]};
        if (bit_q == 4'd9) active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The line is registered once more so it comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= active_q ? sh_q[0] : 1'b1;
    end
  end

endmodule

// File: rtl/shape_dump.sv
// Dumps shapes 0..number of the shape table over the UART as one framed,
// checksummed packet. Each shape is snapshotted in a single LOAD cycle.
module shape_dump
  import shape_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int MAXSHP       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic        [INT_BITS-1:0] number_i,
  output logic        [INT_BITS-1:0] rd_id_o,
  input  logic        [INT_BITS-1:0] rd_ty_i,
  input  logic        [INT_BITS-1:0] rd_x_i,
  input  logic        [INT_BITS-1:0] rd_y_i,
  input  logic        [INT_BITS-1:0] rd_size_i,
  input  logic signed [INT_BITS-1:0] rd_angle_i,
  input  logic        [11:0]         rd_color_i,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [INT_BITS-1:0] LAST_IDX = INT_BITS'(MAXSHP - 1);
  localparam logic [3:0]          LAST_K   = 4'(SHAPE_BYTES - 1);

  state_e              state_q, state_d;
  logic [INT_BITS-1:0] idx_q, idx_d;
  logic [INT_BITS-1:0] num_q, num_d;
  logic [3:0]          k_q, k_d;
  logic [7:0]          csum_q, csum_d;
  shape_t              shp_q, shp_d;
  logic                done_q, done_d;

  logic                u_valid, u_ready, u_busy;
  logic [7:0]          u_data;

  // Only the low byte of the type field goes on the wire.
  logic unused_ty_hi;
  assign unused_ty_hi = ^rd_ty_i[INT_BITS-1:8];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    k_d     = k_q;
    csum_d  = csum_q;
    shp_d   = shp_q;
    done_d  = 1'b0;
    u_valid = 1'b0;
    u_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Clamp so the shape index can never run past the table.
          num_d   = (number_i > LAST_IDX) ? LAST_IDX : number_i;
          idx_d   = '0;
          csum_d  = 8'h00;
          state_d = HDR;
        end
      end
      HDR: begin
        u_valid = 1'b1;
        u_data  = HDR_BYTE;
        if (u_ready) state_d = CNT;
      end
      CNT: begin
        u_valid = 1'b1;
        u_data  = num_q[7:0] + 8'd1;
        if (u_ready) begin
          csum_d  = csum_q ^ u_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shp_d.ty    = rd_ty_i[7:0];
        shp_d.x     = 16'(rd_x_i);
        shp_d.y     = 16'(rd_y_i);
        shp_d.size  = 16'(rd_size_i);
        shp_d.angle = 16'(rd_angle_i);
        shp_d.color = rd_color_i;
        k_d         = '0;
        state_d     = FIELD;
      end
      FIELD: begin
        u_valid = 1'b1;
        u_data  = shape_byte(shp_q, k_q);
        if (u_ready) begin
          csum_d = csum_q ^ u_data;
          if (k_q == LAST_K) begin
            if (idx_q < num_q) begin
              idx_d   = idx_q + INT_BITS'(1);
              state_d = LOAD;
            end else begin
              state_d = CSUM;
            end
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      CSUM: begin
        u_valid = 1'b1;
        u_data  = csum_q;
        if (u_ready) state_d = FIN;
      end
      FIN: begin
        // Serialiser idle means its registered line has one stop cycle left.
        if (!u_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      k_q     <= '0;
      csum_q  <= 8'h00;
      shp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      k_q     <= k_d;
      csum_q  <= csum_d;
      shp_q   <= shp_d;
      done_q  <= done_d;
    end
  end

  assign rd_id_o = idx_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .valid_i(u_valid),
    .ready_o(u_ready),
    .data_i (u_data),
    .tx_o   (tx_o),
    .busy_o (u_busy)
  );

endmodule

// File: tb/tb_shape_dump.sv
// Bench for shape_dump: hand vectors, random tables against a byte-level
// frame model, and mid-frame restart/edit/reset sequences.
module tb_shape_dump;
  import shape_dump_pkg::*;

  localparam int C      = 4;
  localparam int MAXSHP = 16;
  localparam int IB     = INT_BITS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_i = 1'b0;
  logic        [IB-1:0] number_i = '0;
  logic        [IB-1:0] rd_id_o;
  logic        [IB-1:0] rd_ty_i, rd_x_i, rd_y_i, rd_size_i;
  logic signed [IB-1:0] rd_angle_i;
  logic        [11:0]   rd_color_i;
  logic                 tx_o, busy_o, done_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [IB-1:0] t_ty[MAXSHP], t_x[MAXSHP], t_y[MAXSHP], t_sz[MAXSHP];
  int            t_ang[MAXSHP];
  logic [11:0]   t_col[MAXSHP];
  logic [7:0]    exp_q[$];

  always #5 clk = ~clk;

  shape_dump #(.CLKS_PER_BIT(C), .MAXSHP(MAXSHP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .number_i(number_i),
    .rd_id_o(rd_id_o), .rd_ty_i(rd_ty_i), .rd_x_i(rd_x_i), .rd_y_i(rd_y_i),
    .rd_size_i(rd_size_i), .rd_angle_i(rd_angle_i), .rd_color_i(rd_color_i),
    .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always_comb begin
    rd_ty_i = '0; rd_x_i = '0; rd_y_i = '0; rd_size_i = '0;
    rd_angle_i = '0; rd_color_i = '0;
    if (int'(rd_id_o) < MAXSHP) begin
      rd_ty_i    = t_ty[rd_id_o];
      rd_x_i     = t_x[rd_id_o];
      rd_y_i     = t_y[rd_id_o];
      rd_size_i  = t_sz[rd_id_o];
      rd_angle_i = IB'(t_ang[rd_id_o]);
      rd_color_i = t_col[rd_id_o];
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Reference frame built directly from the byte-order rules.
  function automatic void model(input int num);
    logic [7:0] ck;
    int a16;
    int b[11];
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(num + 1));
    ck = 8'(num + 1);
    for (int i = 0; i <= num; i++) begin
      a16   = t_ang[i] & 32'hFFFF;
      b[0]  = int'(t_ty[i]) & 8'hFF;
      b[1]  = int'(t_x[i]) >> 8;   b[2]  = int'(t_x[i]) & 8'hFF;
      b[3]  = int'(t_y[i]) >> 8;   b[4]  = int'(t_y[i]) & 8'hFF;
      b[5]  = int'(t_sz[i]) >> 8;  b[6]  = int'(t_sz[i]) & 8'hFF;
      b[7]  = a16 >> 8;            b[8]  = a16 & 8'hFF;
      b[9]  = int'(t_col[i]) >> 8; b[10] = int'(t_col[i]) & 8'hFF;
      for (int j = 0; j < 11; j++) begin
        exp_q.push_back(8'(b[j]));
        ck = ck ^ 8'(b[j]);
      end
    end
    exp_q.push_back(ck);
  endfunction

  task automatic rand_table();
    for (int i = 0; i < MAXSHP; i++) begin
      t_ty[i]  = IB'($urandom);
      t_x[i]   = IB'(i * 200 + $urandom_range(199));
      t_y[i]   = IB'($urandom);
      t_sz[i]  = IB'($urandom);
      t_ang[i] = int'($urandom_range(359)) - 180;
      t_col[i] = 12'($urandom);
    end
  endtask

  // Leaves the caller at the negedge of cycle 0 (first cycle after the sampling edge).
  task automatic pulse_start(input int num);
    @(negedge clk);
    number_i = IB'(num);
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  // Samples every cycle from cycle 0 against the ideal line/busy/done waveforms.
  task automatic check_frame(input string nm, input int extra);
    logic [7:0] e[$];
    logic       ln[];
    int         rid[$];
    int         n, len, tx_bad, busy_bad, done_bad, nshp;
    logic       etx;
    logic [7:0] v;
    e = exp_q;
    n = e.size();
    len = 2 + n * 10 * C;
    ln = new[len + extra];
    tx_bad = 0; busy_bad = 0; done_bad = 0;
    for (int c = 0; c < len + extra; c++) begin
      etx = 1'b1;
      if (c >= 2 && c < len) begin
        int j, bi, bt;
        j  = c - 2;
        bi = j / (10 * C);
        bt = (j % (10 * C)) / C;
        if (bt == 0) etx = 1'b0;
        else if (bt <= 8) etx = e[bi][bt-1];
      end
      ln[c] = tx_o;
      if (tx_o !== etx) tx_bad++;
      if (busy_o !== (c < len)) busy_bad++;
      if (done_o !== (c == len)) done_bad++;
      if (c < len && (rid.size() == 0 || int'(rd_id_o) != rid[$])) rid.push_back(int'(rd_id_o));
      @(negedge clk);
    end
    chk({nm, " tx_wave_bad_cycles"}, tx_bad, 0);
    chk({nm, " busy_wave_bad_cycles"}, busy_bad, 0);
    chk({nm, " done_wave_bad_cycles"}, done_bad, 0);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) v[b] = ln[2 + i * 10 * C + (b + 1) * C + C / 2];
      chk($sformatf("%s byte%0d", nm, i), int'(v), int'(e[i]));
    end
    nshp = (n - 3) / SHAPE_BYTES;
    chk({nm, " rd_id_steps"}, rid.size(), nshp);
    for (int i = 0; i < rid.size() && i < nshp; i++)
      chk($sformatf("%s rd_id%0d", nm, i), rid[i], i);
  endtask

  typedef struct {
    logic [IB-1:0] ty, x, y, sz;
    int            ang;
    logic [11:0]   col;
    logic [7:0]    b[11];
    logic [7:0]    ck;
  } vec_t;

  vec_t vt[3];

  initial begin
    logic [IB-1:0] ox;
    int bad, num;

    vt[0].ty = 12'd2;   vt[0].x = 12'd300; vt[0].y = 12'd200; vt[0].sz = 12'd50;
    vt[0].ang = -90;    vt[0].col = 12'hF80;
    vt[0].b = '{8'h02, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h00, 8'h32, 8'hFF, 8'hA6, 8'h0F, 8'h80};
    vt[0].ck = 8'h02;
    vt[1].ty = 12'hAB5; vt[1].x = 12'hFFF; vt[1].y = 12'h000; vt[1].sz = 12'h800;
    vt[1].ang = 179;    vt[1].col = 12'h000;
    vt[1].b = '{8'hB5, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00};
    vt[1].ck = 8'hFF;
    vt[2].ty = 12'h001; vt[2].x = 12'h001; vt[2].y = 12'h7FF; vt[2].sz = 12'hFFF;
    vt[2].ang = -180;   vt[2].col = 12'hFFF;
    vt[2].b = '{8'h01, 8'h00, 8'h01, 8'h07, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h4C, 8'h0F, 8'hFF};
    vt[2].ck = 8'h4A;

    rand_table();

    // Reset state, during and right after reset.
    repeat (3) @(negedge clk);
    chk("rst tx", int'(tx_o), 1);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst rd_id", int'(rd_id_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst tx", int'(tx_o), 1);
    chk("post_rst busy", int'(busy_o), 0);
    chk("post_rst done", int'(done_o), 0);
    chk("post_rst rd_id", int'(rd_id_o), 0);

    // Hand vectors, single shape.
    for (int v = 0; v < 3; v++) begin
      t_ty[0] = vt[v].ty; t_x[0] = vt[v].x; t_y[0] = vt[v].y; t_sz[0] = vt[v].sz;
      t_ang[0] = vt[v].ang; t_col[0] = vt[v].col;
      exp_q = {};
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      for (int j = 0; j < 11; j++) exp_q.push_back(vt[v].b[j]);
      exp_q.push_back(vt[v].ck);
      pulse_start(0);
      check_frame($sformatf("vec%0d", v), 6);
    end

    // Full table.
    rand_table();
    model(MAXSHP - 1);
    pulse_start(MAXSHP - 1);
    check_frame("full", 4);

    // Random short frames.
    for (int r = 0; r < 2; r++) begin
      rand_table();
      num = int'($urandom_range(1, 5));
      model(num);
      pulse_start(num);
      check_frame($sformatf("rand%0d", r), 4);
    end

    // start and number changed mid-frame are ignored.
    rand_table();
    model(3);
    pulse_start(3);
    fork
      check_frame("restart", 20);
      begin
        repeat (2 + 5 * 10 * C) @(negedge clk);
        start_i  = 1'b1;
        number_i = IB'(9);
        @(negedge clk);
        start_i  = 1'b0;
      end
    join

    // Shape 1 edited before its snapshot: new value goes out.
    rand_table();
    ox = t_x[1];
    t_x[1] = ox ^ 12'h5A5;
    model(1);
    t_x[1] = ox;
    pulse_start(1);
    fork
      check_frame("edit_early", 4);
      begin
        repeat (2 + 3 * 10 * C) @(negedge clk);
        t_x[1] = ox ^ 12'h5A5;
      end
    join

    // Shape 1 edited while its own bytes stream: old value goes out.
    rand_table();
    ox = t_x[1];
    model(1);
    pulse_start(1);
    fork
      check_frame("edit_late", 4);
      begin
        repeat (2 + 16 * 10 * C) @(negedge clk);
        t_x[1] = ox ^ 12'h5A5;
      end
    join

    // Reset in byte 3 aborts the frame silently; next start is clean.
    rand_table();
    model(2);
    pulse_start(2);
    repeat (2 + 3 * 10 * C + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", int'(tx_o), 1);
    chk("abort busy", int'(busy_o), 0);
    chk("abort done", int'(done_o), 0);
    chk("abort rd_id", int'(rd_id_o), 0);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk("abort quiet_cycles_bad", bad, 0);
    pulse_start(2);
    check_frame("after_abort", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
